pwrmgr_wkup_detector: RTL and testbench

// - Wakeup-request source feeding the power manager's wakeup inputs and its wake-info capture.
// - Per channel: synchronise a raw always-on wakeup signal, optionally glitch-filter it, then detect
//   an edge or timed-level event.
// - Each event sets a sticky cause bit, held until software clears it.

---
 rtl/pwrmgr_pkg.sv | 16 +
 rtl/pwrmgr_wkup_chan.sv | 115 +++++++++++
 rtl/pwrmgr_wkup_detector.sv | 41 ++++
 tb/tb_pwrmgr_wkup_detector.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwrmgr_pkg.sv
// Shared power-manager types and constants used by the wakeup detector.
package pwrmgr_pkg;

    localparam int unsigned WkupModeW = 3;

    // Encodings 6 and 7 are unused and behave like WkupDisabled.
    typedef enum logic [WkupModeW-1:0] {
        WkupDisabled  = 3'd0,
        WkupPosedge   = 3'd1,
        WkupNegedge   = 3'd2,
        WkupAnyedge   = 3'd3,
        WkupTimedHigh = 3'd4,
        WkupTimedLow  = 3'd5
    } wkup_mode_e;

endpackage

// File: rtl/pwrmgr_wkup_chan.sv
// One wakeup channel: 2-flop synchroniser, optional glitch filter,
// edge / timed-level event detect and a sticky cause bit.
module pwrmgr_wkup_chan
    import pwrmgr_pkg::*;
#(
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned FiltCycles = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 raw_i,
    input  logic                 en_i,
    input  logic                 filt_en_i,
    input  logic [WkupModeW-1:0] mode_i,
    input  logic [CntWidth-1:0]  thresh_i,
    input  logic                 clr_i,
    output logic                 cause_o
);

    localparam int unsigned FiltCntW = (FiltCycles > 1) ? $clog2(FiltCycles) : 1;
    localparam logic [FiltCntW-1:0] FiltLast = FiltCntW'(FiltCycles - 1);

    logic [1:0]           sync_q, sync_d;
    logic                 filt_q, filt_d;
    logic [FiltCntW-1:0]  filt_cnt_q, filt_cnt_d;
    logic                 prev_q, prev_d;
    logic [CntWidth-1:0]  lvl_cnt_q, lvl_cnt_d;
    logic [WkupModeW-1:0] mode_q, mode_d;
    logic                 cause_q, cause_d;

    logic                 synced;
    logic                 filtered;
    logic                 mode_chg;
    logic                 lvl_active;
    logic [CntWidth-1:0]  thresh_last;
    logic                 evt;

    always_comb begin
        sync_d     = {sync_q[0], raw_i};
        synced     = sync_q[1];
        filt_d     = filt_q;
        filt_cnt_d = '0;
        filtered   = filt_q;
        lvl_cnt_d  = '0;
        lvl_active = 1'b0;
        evt        = 1'b0;

        // Filter: accept a new level only after FiltCycles consecutive differing cycles.
        if (!filt_en_i) begin
            filtered = synced;
            filt_d   = synced;
        end else if (synced != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_d = synced;
            end else begin
                filt_cnt_d = filt_cnt_q + FiltCntW'(1);
            end
        end

        mode_chg    = (mode_i != mode_q);
        thresh_last = (thresh_i == '0) ? '0 : thresh_i - CntWidth'(1);

        if (en_i && !mode_chg) begin
            if (mode_i == WkupTimedHigh) begin
                lvl_active = filtered;
            end else if (mode_i == WkupTimedLow) begin
                lvl_active = ~filtered;
            end
        end

        if (lvl_active) begin
            lvl_cnt_d = (lvl_cnt_q == '1) ? lvl_cnt_q : lvl_cnt_q + CntWidth'(1);
        end

        case (mode_i)
            WkupPosedge:   evt = filtered & ~prev_q;
            WkupNegedge:   evt = ~filtered & prev_q;
            WkupAnyedge:   evt = filtered ^ prev_q;
            WkupTimedHigh,
            WkupTimedLow:  evt = lvl_active && (lvl_cnt_q == thresh_last);
            default:       evt = 1'b0;
        endcase
        if (mode_chg) begin
            evt = 1'b0;
        end

        // Set wins over a simultaneous clear so no event is lost.
        cause_d = (cause_q & ~clr_i) | (evt & en_i);
        prev_d  = filtered;
        mode_d  = mode_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
            prev_q     <= 1'b0;
            lvl_cnt_q  <= '0;
            mode_q     <= '0;
            cause_q    <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            prev_q     <= prev_d;
            lvl_cnt_q  <= lvl_cnt_d;
            mode_q     <= mode_d;
            cause_q    <= cause_d;
        end
    end

    assign cause_o = cause_q;

endmodule

// File: rtl/pwrmgr_wkup_detector.sv
// Wakeup request source: NumWkups independent detector channels plus the
// request reduction feeding the power manager.
module pwrmgr_wkup_detector
    import pwrmgr_pkg::*;
#(
    parameter int unsigned NumWkups   = 6,
    parameter int unsigned CntWidth   = 16,
    parameter int unsigned FiltCycles = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumWkups-1:0]           wkup_raw_i,
    input  logic [NumWkups-1:0]           en_i,
    input  logic [NumWkups-1:0]           filt_en_i,
    input  logic [WkupModeW*NumWkups-1:0] mode_i,
    input  logic [CntWidth*NumWkups-1:0]  thresh_i,
    input  logic [NumWkups-1:0]           clr_i,
    output logic [NumWkups-1:0]           wakeups_o,
    output logic                          wkup_req_o
);

    for (genvar i = 0; i < NumWkups; i++) begin : g_chan
        pwrmgr_wkup_chan #(
            .CntWidth   (CntWidth),
            .FiltCycles (FiltCycles)
        ) u_chan (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .raw_i     (wkup_raw_i[i]),
            .en_i      (en_i[i]),
            .filt_en_i (filt_en_i[i]),
            .mode_i    (mode_i[WkupModeW*i +: WkupModeW]),
            .thresh_i  (thresh_i[CntWidth*i +: CntWidth]),
            .clr_i     (clr_i[i]),
            .cause_o   (wakeups_o[i])
        );
    end

    assign wkup_req_o = |wakeups_o;

endmodule

// File: tb/tb_pwrmgr_wkup_detector.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a run-length behavioural model.
module tb_pwrmgr_wkup_detector;

    localparam int NW = 6;
    localparam int CW = 16;
    localparam int FC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NW-1:0]   raw, en, filt_en, clr;
    logic [3*NW-1:0] mode;
    logic [CW*NW-1:0] thresh;
    logic [NW-1:0]   wakeups;
    logic            req;

    int checks   = 0;
    int failures = 0;

    pwrmgr_wkup_detector #(
        .NumWkups   (NW),
        .CntWidth   (CW),
        .FiltCycles (FC)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wkup_raw_i (raw),
        .en_i       (en),
        .filt_en_i  (filt_en),
        .mode_i     (mode),
        .thresh_i   (thresh),
        .clr_i      (clr),
        .wakeups_o  (wakeups),
        .wkup_req_o (req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [NW-1:0] exp);
        check({name, "_wakeups"}, 32'(wakeups), 32'(exp));
        check({name, "_req"}, 32'(req), 32'(|exp));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_mode(input int ch, input int m);
        mode[3*ch +: 3] = 3'(m);
    endtask

    task automatic set_thresh(input int ch, input int t);
        thresh[CW*ch +: CW] = CW'(t);
    endtask

    // Model: raw delayed two cycles, filter as a run of differing cycles,
    // timed modes as a run of qualifying level cycles.
    int m_s1[NW], m_s2[NW], m_filt[NW], m_drun[NW], m_prev[NW];
    int m_run[NW], m_mprev[NW], m_cause[NW];
    int md, th, f;
    bit ev, qual;
    logic [NW-1:0] m_exp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NW; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_filt[i] = 0; m_drun[i] = 0;
                m_prev[i] = 0; m_run[i] = 0; m_mprev[i] = 0; m_cause[i] = 0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                md = int'(mode[3*i +: 3]);
                th = int'(thresh[CW*i +: CW]);
                if (th == 0) th = 1;
                f = filt_en[i] ? m_filt[i] : m_s2[i];
                qual = en[i] && (md == m_mprev[i]) &&
                       ((md == 4 && f == 1) || (md == 5 && f == 0));
                ev = 1'b0;
                if (md == m_mprev[i]) begin
                    case (md)
                        1: ev = (f == 1) && (m_prev[i] == 0);
                        2: ev = (f == 0) && (m_prev[i] == 1);
                        3: ev = (f != m_prev[i]);
                        4, 5: ev = qual && (m_run[i] + 1 == th);
                        default: ev = 1'b0;
                    endcase
                end
                m_cause[i] = ((m_cause[i] != 0) && !clr[i]) || (ev && en[i]) ? 1 : 0;
                m_run[i] = qual ? m_run[i] + 1 : 0;
                if (!filt_en[i]) begin
                    m_filt[i] = m_s2[i];
                    m_drun[i] = 0;
                end else if (m_s2[i] != m_filt[i]) begin
                    if (m_drun[i] + 1 == FC) begin
                        m_filt[i] = m_s2[i];
                        m_drun[i] = 0;
                    end else begin
                        m_drun[i] = m_drun[i] + 1;
                    end
                end else begin
                    m_drun[i] = 0;
                end
                m_prev[i]  = f;
                m_s2[i]    = m_s1[i];
                m_s1[i]    = int'(raw[i]);
                m_mprev[i] = md;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NW; i++) m_exp[i] = (m_cause[i] != 0);
            check("model_wakeups", 32'(wakeups), 32'(m_exp));
            check("model_req", 32'(req), 32'(|m_exp));
        end
    end

    initial begin
        rst_n = 1'b0;
        raw = '0; en = '0; filt_en = '0; clr = '0; mode = '0; thresh = '0;
        #12;
        chk_w("reset", 6'b000000);
        @(negedge clk) rst_n = 1'b1;
        tick(1);

        // Posedge, filter off: cause after exactly three edges.
        en = '1;
        set_mode(0, 1);
        tick(2);
        raw[0] = 1'b1;
        tick(1); chk_w("pos_e0", 6'b000000);
        tick(1); chk_w("pos_e1", 6'b000000);
        tick(1); chk_w("pos_e2", 6'b000001);
        raw[0] = 1'b0; clr[0] = 1'b1;
        tick(1); clr = '0;
        chk_w("pos_clr", 6'b000000);

        // Filter on: short glitch dropped, long pulse delayed by FC.
        filt_en[0] = 1'b1;
        tick(4);
        raw[0] = 1'b1; tick(3); raw[0] = 1'b0;
        tick(12); chk_w("filt_glitch", 6'b000000);
        raw[0] = 1'b1;
        tick(6); chk_w("filt_e5", 6'b000000);
        tick(1); chk_w("filt_e6", 6'b000001);
        clr[0] = 1'b1; raw[0] = 1'b0;
        tick(1); clr = '0; filt_en = '0;
        tick(10); chk_w("filt_fall", 6'b000000);

        // Timed high, threshold 10.
        set_mode(1, 4); set_thresh(1, 10);
        tick(2);
        raw[1] = 1'b1; tick(9); raw[1] = 1'b0;
        tick(5); chk_w("th_9", 6'b000000);
        raw[1] = 1'b1; tick(10); raw[1] = 1'b0;
        tick(5); chk_w("th_10", 6'b000010);
        clr[1] = 1'b1; tick(1); clr = '0;
        chk_w("th_clr", 6'b000000);
        raw[1] = 1'b1; tick(100); chk_w("th_100", 6'b000010);
        clr[1] = 1'b1; tick(1); clr = '0;
        tick(50); chk_w("th_norefire", 6'b000000);
        raw[1] = 1'b0; tick(4);
        set_thresh(1, 0); tick(1);
        raw[1] = 1'b1;
        tick(2); chk_w("th0_e1", 6'b000000);
        tick(1); chk_w("th0_e2", 6'b000010);
        raw[1] = 1'b0; clr[1] = 1'b1; tick(1); clr = '0;
        set_mode(1, 0); tick(3);
        chk_w("th0_clr", 6'b000000);

        // Clear racing a set on channel 2.
        set_mode(2, 1); tick(2);
        raw[2] = 1'b1; tick(2);
        clr[2] = 1'b1; tick(1); clr = '0;
        chk_w("race_set", 6'b000100);
        clr[2] = 1'b1; tick(1); clr = '0;
        chk_w("race_clr", 6'b000000);
        raw[2] = 1'b0; tick(3);

        // Disabled channels ignore edges; re-enable with level high gives nothing.
        en = '0;
        set_mode(0, 1); set_mode(1, 2); set_mode(2, 3);
        set_mode(3, 4); set_mode(4, 5); set_mode(5, 1);
        set_thresh(3, 1); set_thresh(4, 1);
        tick(2);
        for (int k = 0; k < 6; k++) begin
            raw = ~raw; tick(3);
        end
        chk_w("en0_toggle", 6'b000000);
        raw = '1; tick(6); chk_w("en0_high", 6'b000000);
        en = 6'b100001; tick(6);
        chk_w("reen_high", 6'b000000);

        // Reset in the middle of a timed-low count.
        en = 6'b010001; set_thresh(4, 8);
        raw[0] = 1'b0; tick(4);
        raw[0] = 1'b1; tick(4);
        chk_w("pre_rst", 6'b000001);
        raw[4] = 1'b0; tick(7);
        chk_w("tl_cnt5", 6'b000001);
        en = 6'b010000;
        rst_n = 1'b0;
        #1;
        chk_w("mid_rst", 6'b000000);
        #20;
        @(negedge clk) rst_n = 1'b1;
        tick(8); chk_w("tl_e7", 6'b000000);
        tick(1); chk_w("tl_e8", 6'b010000);

        // Randomized traffic against the model.
        en = '1;
        for (int i = 0; i < NW; i++) begin
            set_mode(i, int'($urandom_range(7)));
            set_thresh(i, int'($urandom_range(12)));
        end
        filt_en = NW'($urandom);
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NW; i++) begin
                if ($urandom_range(5) == 0) raw[i] = ~raw[i];
            end
            clr = '0;
            if ($urandom_range(7) == 0) clr[$urandom_range(NW-1)] = 1'b1;
            if ($urandom_range(199) == 0) en = NW'($urandom);
            if ($urandom_range(149) == 0) filt_en = NW'($urandom);
            if ($urandom_range(99) == 0) set_mode(int'($urandom_range(NW-1)), int'($urandom_range(7)));
            if ($urandom_range(99) == 0) set_thresh(int'($urandom_range(NW-1)), int'($urandom_range(12)));
            if (c == 2000) begin
                rst_n = 1'b0;
                #1;
                chk_w("rand_rst", 6'b000000);
                #13;
                @(negedge clk) rst_n = 1'b1;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
